// File: rtl/spin_cycle_controller.sv
// Purpose  : spin-phase drum sequencer with ramped speed, imbalance retry, pause/resume and abort.
// Latency  : every output is registered; a sampled input affects the outputs one clock later.
// Backpres.: none; spin_req is a level handshake and dropping it starts a controlled ramp-down.
// Ports    : clk, reset (async, active-high), spin_req, target_speed[3:0], pause, continue_signal,
//            vibration_sensor -> drum_motor[3:0], spin_active, spin_done, vibration_error, retry_count[1:0].
module spin_cycle_controller #(
   parameter int RAMP_STEP_CYCLES = 4,
   parameter int HOLD_CYCLES      = 40,
   parameter int REDIST_CYCLES    = 8,
   parameter int MAX_RETRIES      = 3
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       spin_req,
   input  logic [3:0] target_speed,
   input  logic       pause,
   input  logic       continue_signal,
   input  logic       vibration_sensor,
   output logic [3:0] drum_motor,
   output logic       spin_active,
   output logic       spin_done,
   output logic       vibration_error,
   output logic [1:0] retry_count
);

   typedef enum logic [3:0] {
      S_IDLE, S_RAMP_UP, S_HOLD, S_RAMP_DOWN, S_REDIST,
      S_PAUSING, S_PAUSED, S_ABORTING, S_DONE, S_FAULT
   } state_t;

   localparam logic [7:0] STEP_LAST   = 8'(RAMP_STEP_CYCLES - 1);
   localparam logic [7:0] HOLD_LAST   = 8'(HOLD_CYCLES - 1);
   localparam logic [7:0] REDIST_LAST = 8'(REDIST_CYCLES - 1);
   localparam logic [1:0] RETRY_MAX   = 2'(MAX_RETRIES);

   state_t     state;
   logic [7:0] step_cnt;     // shared by ramps (step timer) and REDIST (tumble timer)
   logic [7:0] hold_cnt;
   logic [7:0] saved_hold;   // HOLD progress captured when a pause interrupts HOLD
   logic [3:0] tgt_q;
   logic       resume_hold;  // next arrival at tgt_q continues HOLD from saved_hold
   logic       resume_down;  // pause interrupted RAMP_DOWN: resume goes straight back there

   logic step_wrap;
   logic vib_state;
   logic pause_state;

   assign step_wrap   = (step_cnt == STEP_LAST);
   assign vib_state   = (state == S_RAMP_UP) || (state == S_HOLD);
   assign pause_state = vib_state || (state == S_RAMP_DOWN) || (state == S_REDIST);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state           <= S_IDLE;
         drum_motor      <= '0;
         spin_active     <= 1'b0;
         spin_done       <= 1'b0;
         vibration_error <= 1'b0;
         retry_count     <= '0;
         step_cnt        <= '0;
         hold_cnt        <= '0;
         saved_hold      <= '0;
         tgt_q           <= '0;
         resume_hold     <= 1'b0;
         resume_down     <= 1'b0;
      end else begin
         spin_done <= 1'b0;
         case (state)
            S_IDLE: begin
               if (spin_req) begin
                  step_cnt <= '0;
                  if (target_speed != 4'd0) begin
                     tgt_q       <= target_speed;
                     retry_count <= '0;
                     resume_hold <= 1'b0;
                     resume_down <= 1'b0;
                     drum_motor  <= '0;
                     spin_active <= 1'b1;
                     state       <= S_RAMP_UP;
                  end else begin
                     // zero target: nothing to spin, report completion at once
                     spin_done <= 1'b1;
                     state     <= S_DONE;
                  end
               end
            end
            S_DONE, S_FAULT: begin
               if (!spin_req) state <= S_IDLE;
            end
            default: begin
               // active states; priority is abort > vibration > pause > normal step
               if (!spin_req && (state != S_ABORTING)) begin
                  step_cnt <= '0;
                  state    <= S_ABORTING;
               end else if (vibration_sensor && vib_state) begin
                  step_cnt    <= '0;
                  resume_hold <= 1'b0;
                  if (retry_count < RETRY_MAX) begin
                     retry_count <= retry_count + 2'd1;
                     drum_motor  <= 4'd1;
                     state       <= S_REDIST;
                  end else begin
                     drum_motor      <= '0;
                     vibration_error <= 1'b1;
                     spin_active     <= 1'b0;
                     state           <= S_FAULT;
                  end
               end else if (pause && pause_state) begin
                  step_cnt    <= '0;
                  state       <= S_PAUSING;
                  resume_down <= (state == S_RAMP_DOWN);
                  // a pause during RAMP_UP keeps any HOLD progress saved by an earlier pause
                  if (state == S_HOLD) begin
                     saved_hold  <= hold_cnt;
                     resume_hold <= 1'b1;
                  end else if (state != S_RAMP_UP) begin
                     resume_hold <= 1'b0;
                  end
               end else begin
                  case (state)
                     S_RAMP_UP: begin
                        // drum already at target only happens when REDIST hands over with tgt_q=1
                        if ((drum_motor == tgt_q) || (step_wrap && ((drum_motor + 4'd1) == tgt_q))) begin
                           if (drum_motor != tgt_q) drum_motor <= drum_motor + 4'd1;
                           step_cnt    <= '0;
                           hold_cnt    <= resume_hold ? saved_hold : '0;
                           resume_hold <= 1'b0;
                           state       <= S_HOLD;
                        end else if (step_wrap) begin
                           drum_motor <= drum_motor + 4'd1;
                           step_cnt   <= '0;
                        end else begin
                           step_cnt <= step_cnt + 8'd1;
                        end
                     end
                     S_HOLD: begin
                        if (hold_cnt == HOLD_LAST) begin
                           step_cnt <= '0;
                           state    <= S_RAMP_DOWN;
                        end else begin
                           hold_cnt <= hold_cnt + 8'd1;
                        end
                     end
                     S_REDIST: begin
                        if (step_cnt == REDIST_LAST) begin
                           step_cnt <= '0;
                           state    <= S_RAMP_UP;
                        end else begin
                           step_cnt <= step_cnt + 8'd1;
                        end
                     end
                     S_PAUSED: begin
                        if (continue_signal) begin
                           step_cnt    <= '0;
                           resume_down <= 1'b0;
                           state       <= resume_down ? S_RAMP_DOWN : S_RAMP_UP;
                        end
                     end
                     default: begin
                        // RAMP_DOWN, PAUSING, ABORTING share the ramp; only the landing state differs
                        if ((drum_motor == 4'd0) || (step_wrap && (drum_motor == 4'd1))) begin
                           drum_motor <= '0;
                           step_cnt   <= '0;
                           if (state == S_RAMP_DOWN) begin
                              spin_done   <= 1'b1;
                              spin_active <= 1'b0;
                              state       <= S_DONE;
                           end else if (state == S_PAUSING) begin
                              state <= S_PAUSED;
                           end else begin
                              spin_active <= 1'b0;
                              state       <= S_IDLE;
                           end
                        end else if (step_wrap) begin
                           drum_motor <= drum_motor - 4'd1;
                           step_cnt   <= '0;
                        end else begin
                           step_cnt <= step_cnt + 8'd1;
                        end
                     end
                  endcase
               end
            end
         endcase
      end
   end

endmodule

// File: tb/tb_spin_cycle_controller.sv
// Bench for spin_cycle_controller: directed spin scenarios followed by randomized stimulus,
// all outputs compared every clock against a phase/countdown reference model.
module tb_spin_cycle_controller;

   localparam int RAMP   = 4;
   localparam int HOLD   = 40;
   localparam int REDIST = 8;
   localparam int MAXRT  = 3;

   logic       clk = 1'b0;
   logic       reset;
   logic       spin_req;
   logic [3:0] target_speed;
   logic       pause;
   logic       continue_signal;
   logic       vibration_sensor;
   logic [3:0] drum_motor;
   logic       spin_active;
   logic       spin_done;
   logic       vibration_error;
   logic [1:0] retry_count;

   int vectors     = 0;
   int miscompares = 0;
   int done_cnt    = 0;

   always #5 clk = ~clk;

   spin_cycle_controller dut (
      .clk              (clk),
      .reset            (reset),
      .spin_req         (spin_req),
      .target_speed     (target_speed),
      .pause            (pause),
      .continue_signal  (continue_signal),
      .vibration_sensor (vibration_sensor),
      .drum_motor       (drum_motor),
      .spin_active      (spin_active),
      .spin_done        (spin_done),
      .vibration_error  (vibration_error),
      .retry_count      (retry_count)
   );

   // ---------------- reference model ----------------
   typedef enum {P_IDLE, P_UP, P_HOLD, P_DOWN, P_TUMBLE, P_PSTOP, P_PAUSED, P_ABORT, P_DONE, P_FAULT} phase_e;
   phase_e ph;
   int  m_speed, m_tgt, m_retries, m_ticks_left, m_hold_elapsed, m_saved_hold, m_tumble_left;
   bit  m_err, m_done, m_res_hold, m_res_down;

   function automatic bit m_active();
      return !(ph inside {P_IDLE, P_DONE, P_FAULT});
   endfunction

   task automatic m_reset();
      ph = P_IDLE; m_speed = 0; m_tgt = 0; m_retries = 0; m_ticks_left = RAMP;
      m_hold_elapsed = 0; m_saved_hold = 0; m_tumble_left = 0;
      m_err = 0; m_done = 0; m_res_hold = 0; m_res_down = 0;
   endtask

   task automatic m_enter(input phase_e p);
      ph = p;
      m_ticks_left = RAMP;
   endtask

   task automatic m_enter_hold();
      m_hold_elapsed = m_res_hold ? m_saved_hold : 0;
      m_res_hold = 0;
      m_enter(P_HOLD);
   endtask

   // landing point of a completed ramp to zero
   task automatic m_land();
      if (ph == P_DOWN) begin m_enter(P_DONE); m_done = 1; end
      else if (ph == P_PSTOP) m_enter(P_PAUSED);
      else m_enter(P_IDLE);
   endtask

   task automatic m_normal();
      case (ph)
         P_UP: begin
            if (m_speed == m_tgt) m_enter_hold();
            else begin
               m_ticks_left--;
               if (m_ticks_left == 0) begin
                  m_speed++;
                  m_ticks_left = RAMP;
                  if (m_speed == m_tgt) m_enter_hold();
               end
            end
         end
         P_HOLD: begin
            m_hold_elapsed++;
            if (m_hold_elapsed == HOLD) m_enter(P_DOWN);
         end
         P_TUMBLE: begin
            m_tumble_left--;
            if (m_tumble_left == 0) m_enter(P_UP);
         end
         P_PAUSED: begin
            if (continue_signal) begin
               if (m_res_down) begin m_res_down = 0; m_enter(P_DOWN); end
               else m_enter(P_UP);
            end
         end
         default: begin
            if (m_speed == 0) m_land();
            else begin
               m_ticks_left--;
               if (m_ticks_left == 0) begin
                  m_speed--;
                  m_ticks_left = RAMP;
                  if (m_speed == 0) m_land();
               end
            end
         end
      endcase
   endtask

   task automatic m_step();
      m_done = 0;
      if (reset) begin m_reset(); return; end
      case (ph)
         P_IDLE: begin
            if (spin_req) begin
               if (target_speed != 0) begin
                  m_tgt = int'(target_speed); m_retries = 0; m_speed = 0;
                  m_res_hold = 0; m_res_down = 0;
                  m_enter(P_UP);
               end else begin
                  m_enter(P_DONE); m_done = 1;
               end
            end
         end
         P_DONE, P_FAULT: if (!spin_req) m_enter(P_IDLE);
         default: begin
            if (!spin_req && ph != P_ABORT) m_enter(P_ABORT);
            else if (vibration_sensor && (ph == P_UP || ph == P_HOLD)) begin
               m_res_hold = 0;
               if (m_retries < MAXRT) begin
                  m_retries++; m_speed = 1; m_tumble_left = REDIST; m_enter(P_TUMBLE);
               end else begin
                  m_speed = 0; m_err = 1; m_enter(P_FAULT);
               end
            end else if (pause && (ph inside {P_UP, P_HOLD, P_DOWN, P_TUMBLE})) begin
               m_res_down = (ph == P_DOWN);
               if (ph == P_HOLD) begin m_saved_hold = m_hold_elapsed; m_res_hold = 1; end
               else if (ph != P_UP) m_res_hold = 0;
               m_enter(P_PSTOP);
            end else m_normal();
         end
      endcase
   endtask

   // ---------------- checking ----------------
   task automatic chk(input string tag, input int obs, input int exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic compare_all();
      chk("drum_motor", int'(drum_motor), m_speed);
      chk("spin_active", int'(spin_active), int'(m_active()));
      chk("spin_done", int'(spin_done), int'(m_done));
      chk("vibration_error", int'(vibration_error), int'(m_err));
      chk("retry_count", int'(retry_count), m_retries);
   endtask

   task automatic step_clk();
      @(posedge clk);
      m_step();
      #1;
      compare_all();
      if (spin_done === 1'b1) done_cnt++;
   endtask

   task automatic wait_drum(input int val, input int max, output int n);
      n = 0;
      while (int'(drum_motor) != val && n < max) begin
         step_clk();
         n++;
      end
   endtask

   task automatic vib_pulse();
      vibration_sensor = 1'b1;
      step_clk();
      vibration_sensor = 1'b0;
   endtask

   task automatic go_idle();
      spin_req = 1'b0;
      repeat (2) step_clk();
   endtask

   initial begin
      int n;
      int d0;
      reset = 1'b1; spin_req = 1'b0; target_speed = 4'd0; pause = 1'b0;
      continue_signal = 1'b0; vibration_sensor = 1'b0;
      m_reset();
      repeat (2) @(posedge clk);
      #1;
      compare_all();
      reset = 1'b0;

      // 1: normal run to 8; a stray continue_signal must be ignored
      d0 = done_cnt;
      spin_req = 1'b1; target_speed = 4'd8; continue_signal = 1'b1;
      step_clk();
      wait_drum(8, 100, n);  chk("t1_ramp_up_clocks", n, 32);
      continue_signal = 1'b0;
      wait_drum(7, 100, n);  chk("t1_hold_plus_step_clocks", n, HOLD + RAMP);
      wait_drum(0, 100, n);  chk("t1_ramp_down_rest", n, 7 * RAMP);
      chk("t1_done_pulses", done_cnt - d0, 1);
      chk("t1_active_after", int'(spin_active), 0);
      go_idle();
      chk("t1_single_pulse", done_cnt - d0, 1);

      // 2: one vibration pulse at speed 5
      d0 = done_cnt;
      spin_req = 1'b1; target_speed = 4'd8;
      step_clk();
      wait_drum(5, 100, n);
      vib_pulse();
      chk("t2_tumble_speed", int'(drum_motor), 1);
      chk("t2_retry", int'(retry_count), 1);
      wait_drum(2, 100, n);  chk("t2_tumble_then_first_step", n, REDIST + RAMP);
      wait_drum(8, 100, n);  chk("t2_reach_target", int'(drum_motor), 8);
      wait_drum(0, 200, n);
      chk("t2_done_pulses", done_cnt - d0, 1);
      go_idle();

      // 3: four vibration events -> fault, sticky flag
      spin_req = 1'b1; target_speed = 4'd6;
      step_clk();
      for (int i = 1; i <= 3; i++) begin
         wait_drum(3, 100, n);
         vib_pulse();
         chk("t3_retry", int'(retry_count), i);
      end
      wait_drum(3, 100, n);
      vib_pulse();
      chk("t3_fault_flag", int'(vibration_error), 1);
      chk("t3_fault_drum", int'(drum_motor), 0);
      chk("t3_fault_inactive", int'(spin_active), 0);
      go_idle();
      repeat (3) step_clk();
      chk("t3_flag_sticky", int'(vibration_error), 1);
      reset = 1'b1; m_reset(); #1;
      chk("t3_flag_cleared", int'(vibration_error), 0);
      step_clk();
      reset = 1'b0;

      // 4: pause after 20 HOLD clocks, resume and finish the remaining 20
      d0 = done_cnt;
      spin_req = 1'b1; target_speed = 4'd8;
      step_clk();
      wait_drum(8, 100, n);
      repeat (20) step_clk();
      pause = 1'b1; step_clk(); pause = 1'b0;
      wait_drum(0, 100, n);  chk("t4_pause_ramp_clocks", n, 32);
      repeat (5) step_clk();
      chk("t4_paused_active", int'(spin_active), 1);
      chk("t4_paused_drum", int'(drum_motor), 0);
      continue_signal = 1'b1; step_clk(); continue_signal = 1'b0;
      wait_drum(8, 100, n);  chk("t4_resume_ramp_clocks", n, 32);
      wait_drum(7, 100, n);  chk("t4_remaining_hold_plus_step", n, 20 + RAMP);
      wait_drum(0, 100, n);
      chk("t4_done_pulses", done_cnt - d0, 1);
      go_idle();

      // 5: abort during HOLD
      d0 = done_cnt;
      spin_req = 1'b1; target_speed = 4'd8;
      step_clk();
      wait_drum(8, 100, n);
      repeat (5) step_clk();
      spin_req = 1'b0;
      wait_drum(0, 100, n);  chk("t5_abort_clocks", n, 1 + 32);
      chk("t5_inactive", int'(spin_active), 0);
      step_clk();
      chk("t5_no_done", done_cnt - d0, 0);

      // 6: reset mid-ramp, then zero-target request
      spin_req = 1'b1; target_speed = 4'd5;
      step_clk();
      repeat (10) step_clk();
      reset = 1'b1; m_reset(); #1;
      compare_all();
      chk("t6_reset_drum", int'(drum_motor), 0);
      step_clk();
      reset = 1'b0;
      spin_req = 1'b1; target_speed = 4'd0;
      step_clk();
      chk("t6_zero_target_done", int'(spin_done), 1);
      step_clk();
      chk("t6_done_single", int'(spin_done), 0);
      go_idle();

      // randomized traffic against the model
      for (int c = 0; c < 4000; c++) begin
         spin_req         = ($urandom_range(99) < 98);
         target_speed     = 4'($urandom_range(15));
         pause            = ($urandom_range(99) < 2);
         continue_signal  = ($urandom_range(99) < 10);
         vibration_sensor = ($urandom_range(99) < 2);
         if ($urandom_range(999) < 3) begin
            reset = 1'b1;
            m_reset();
         end
         step_clk();
         reset = 1'b0;
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
